// File: rtl/uart_core_param.sv
// Full-duplex parametrised UART: TX serialiser, oversampled RX deserialiser and RX FIFO.
// Optional parity bit in both directions when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_core_param #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- TX ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [BW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_buf, tx_buf_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_buf   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_buf   <= tx_buf_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_buf_n   = tx_buf;
    tx_ready   = 1'b0;
    tx         = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        tx_cnt_n = '0;
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_buf_n   = tx_data;
          tx_idx_n   = '0;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx = tx_buf[tx_idx];
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          if (tx_idx == LAST_BIT) begin
            tx_idx_n = '0;
`ifdef UART_PARITY_EN
            tx_state_n = TX_PARITY;
`else
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_idx_n = tx_idx + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx = (^tx_buf) ^ PARITY_ODD;
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [BW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 push_q, push_n;
  logic                 ferr_q, ferr_n;
  logic                 ovr_q;
`ifdef UART_PARITY_EN
  logic                 par_q, par_n;
  logic                 perr_q, perr_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      push_q   <= push_n;
      ferr_q   <= ferr_n;
`ifdef UART_PARITY_EN
      par_q    <= par_n;
      perr_q   <= perr_n;
`endif
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    push_n     = 1'b0;
    ferr_n     = 1'b0;
`ifdef UART_PARITY_EN
    par_n      = par_q;
    perr_n     = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        // Mid-start resample: a line already back high was a glitch
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end else begin
            rx_idx_n = rx_idx + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          par_n      = rx_s2;
          rx_state_n = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          if (!rx_s2) begin
            ferr_n     = 1'b1;
            rx_state_n = RX_WAIT;
          end
`ifdef UART_PARITY_EN
          else if (((^rx_shift) ^ PARITY_ODD) != par_q) begin
            perr_n     = 1'b1;
            rx_state_n = RX_IDLE;
          end
`endif
          else begin
            push_n     = 1'b1;
            rx_state_n = RX_IDLE;
          end
        end
      end
      RX_WAIT: begin
        rx_cnt_n = '0;
        if (rx_s2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, pop, do_push;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid = (wr_ptr != rd_ptr);
  assign pop     = rx_valid && rx_ready;
  // Pop frees the head slot in the same edge, so a full FIFO can still accept
  assign do_push = push_q && (!full || pop);
  assign rx_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      ovr_q <= push_q && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Loopback bench for uart_core_param (tx -> rx), with a line override for error injection.
`timescale 1ns/1ps
module tb_uart_core_param;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int SETTLE    = 16 * FB + 15;
  localparam int PUSH_EDGE = 16 * FB - 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_frame_err, rx_parity_err, rx_overrun;
  logic       force_en = 1'b0;
  logic       force_val = 1'b1;
  logic       rx_line;

  assign rx_line = force_en ? force_val : tx;
  always #5 clk = ~clk;

  uart_core_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(16), .FIFO_DEPTH(4), .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
    .rx(rx_line),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  int pass_cnt = 0, total_cnt = 0;
  int ferr_n = 0, perr_n = 0, ovr_n = 0;

  always @(negedge clk) begin
    if (rx_frame_err)  ferr_n++;
    if (rx_parity_err) perr_n++;
    if (rx_overrun)    ovr_n++;
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 400) begin
      tick(1);
      t++;
    end
    if (!tx_ready) check("tx_ready_wait", 0, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         corrupt_stop;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int f0, p0, o0;
    logic [7:0] b;
    logic       exp_bit;

    vecs[0] = '{8'hF5, 1'b0, 1'b1, 8'hF5, 0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'hA3, 1'b1, 1'b0, 8'h00, 1};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 0};

    // Reset state
    #3;
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    @(negedge clk) reset = 1'b1;
    tick(4);

    // Serial bit pattern of 8'hF5, LSB first, then idle
    b = 8'hF5;
    send(b);
    tick(8);
    for (int k = 0; k <= FB; k++) begin
      if (k == 0) exp_bit = 1'b0;
      else if (k <= 8) exp_bit = b[k-1];
`ifdef UART_PARITY_EN
      else if (k == 9) exp_bit = 1'b0;
`endif
      else exp_bit = 1'b1;
      check($sformatf("f5_bit%0d", k), tx, exp_bit);
      if (k < FB) tick(16);
    end
    tick(SETTLE - 8 - 16 * FB);
    check("f5_rx_valid", rx_valid, 1);
    check("f5_rx_data", rx_data, 8'hF5);
    pop();

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_n; o0 = ovr_n;
      send(vecs[i].data);
      if (vecs[i].corrupt_stop) begin
        tick(16 * (FB - 1));
        force_val = 1'b0; force_en = 1'b1;
        tick(18);
        force_en = 1'b0;
        tick(SETTLE - 16 * (FB - 1) - 18);
      end else begin
        tick(SETTLE);
      end
      check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), ferr_n - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), ovr_n - o0, 0);
      if (rx_valid) pop();
      check($sformatf("vec%0d_empty", i), rx_valid, 0);
    end

    // Overrun: five frames with no pops keep the first four
    o0 = ovr_n;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    tick(SETTLE);
    check("ovr_pulse", ovr_n - o0, 1);
    check("ovr_head", rx_data, 8'h11);
    // Full FIFO with pop in the push cycle: no overrun
    o0 = ovr_n;
    send(8'h66);
    tick(PUSH_EDGE);
    pop();
    tick(SETTLE - PUSH_EDGE - 1);
    check("fullpop_ovr", ovr_n - o0, 0);
    check("fifo0", rx_data, 8'h22); pop();
    check("fifo1", rx_data, 8'h33); pop();
    check("fifo2", rx_data, 8'h44); pop();
    check("fifo3", rx_data, 8'h66); pop();
    check("fifo_empty", rx_valid, 0);

    // Short low glitch on rx is rejected
    f0 = ferr_n; p0 = perr_n; o0 = ovr_n;
    force_val = 1'b0; force_en = 1'b1;
    tick(4);
    force_en = 1'b0;
    tick(40);
    check("glitch_valid", rx_valid, 0);
    check("glitch_flags", (ferr_n - f0) + (perr_n - p0) + (ovr_n - o0), 0);

    // tx_valid while busy is ignored; tx_ready returns the cycle after STOP
    send(8'h3C);
    tick(40);
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(16 * FB - 1 - 41);
    check("busy_ready_low", tx_ready, 0);
    tick(1);
    check("busy_ready_high", tx_ready, 1);
    tick(15);
    check("busy_rx_data", rx_data, 8'h3C);
    pop();
    tick(SETTLE);
    check("busy_no_second", rx_valid, 0);

`ifdef UART_PARITY_EN
    // Flipped parity bit
    f0 = ferr_n; p0 = perr_n;
    send(8'hF5);
    tick(16 * (FB - 2));
    force_val = 1'b1; force_en = 1'b1;
    tick(16);
    force_en = 1'b0;
    tick(SETTLE - 16 * (FB - 1));
    check("par_err", perr_n - p0, 1);
    check("par_ferr", ferr_n - f0, 0);
    check("par_valid", rx_valid, 0);
`else
    check("par_tied0", perr_n, 0);
`endif

    // Reset mid-frame with a non-empty FIFO
    send(8'h77);
    tick(SETTLE);
    check("mid_pre_valid", rx_valid, 1);
    send(8'h99);
    tick(50);
    check("mid_tx_busy", tx_ready, 0);
    f0 = ferr_n; p0 = perr_n; o0 = ovr_n;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_valid", rx_valid, 0);
    @(negedge clk) reset = 1'b1;
    tick(SETTLE);
    check("mid_post_valid", rx_valid, 0);
    check("mid_post_flags", (ferr_n - f0) + (perr_n - p0) + (ovr_n - o0), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
